// File: rtl/serial_rx_unstriper_if.sv
// Bus between the serial line, the receive un-striper and the four lane consumers.
// The un-striper takes the slave side; whoever drives serial_in takes the master side.
interface serial_rx_unstriper_if;
   logic       serial_in;
   logic [7:0] dataOut0;
   logic [7:0] dataOut1;
   logic [7:0] dataOut2;
   logic [7:0] dataOut3;
   logic       validOut0;
   logic       validOut1;
   logic       validOut2;
   logic       validOut3;
   logic       strobe_out;
   logic       active;

   // No back-pressure: one serial bit is taken every clk_32f cycle. A word is
   // qualified only by strobe_out (one cycle), and the lane outputs hold in between.
   modport master (
      output serial_in,
      input  dataOut0, dataOut1, dataOut2, dataOut3,
      input  validOut0, validOut1, validOut2, validOut3,
      input  strobe_out, active
   );

   modport slave (
      input  serial_in,
      output dataOut0, dataOut1, dataOut2, dataOut3,
      output validOut0, validOut1, validOut2, validOut3,
      output strobe_out, active
   );
endinterface

// File: rtl/serial_rx_unstriper.sv
// Four-lane serial receiver: hunts comma byte alignment, then un-stripes bytes onto lanes 0..3.
// Optional macro RX_RESYNC_EN drops back to hunting after repeated slipped commas.
module serial_rx_unstriper #(
   parameter logic [7:0] COMMA          = 8'hBC,
   parameter int         SYNC_COUNT     = 4,
   parameter int         MISALIGN_LIMIT = 4
) (
   input  logic                 clk_32f,
   input  logic                 reset,
   serial_rx_unstriper_if.slave link,
   output logic [1:0]           stateDbg
);
   localparam int CW = $clog2(SYNC_COUNT);

   if (SYNC_COUNT < 4 || (SYNC_COUNT % 4) != 0) begin : gBadSync
      $error("SYNC_COUNT must be a multiple of 4 and at least 4");
   end
   if (MISALIGN_LIMIT < 1) begin : gBadLimit
      $error("MISALIGN_LIMIT must be at least 1");
   end

   typedef enum logic [1:0] {HUNT = 2'd0, LOCK = 2'd1, ACTIVE = 2'd2} state_t;

   state_t        state;
   state_t        stateNext;
   logic [7:0]    sr;
   logic [7:0]    window;
   logic [2:0]    bitCnt;
   logic [CW-1:0] commaCnt;
   logic [1:0]    laneCnt;
   logic [7:0]    stageData [4];
   logic [3:0]    stageValid;
   logic          wordDone;
   logic [7:0]    dataR [4];
   logic [3:0]    validR;
   logic          strobeR;
   logic          activeR;

   logic byteEnd, match, huntHit, lockComma, lockBreak, syncDone, resync, stageEn;

`ifdef RX_RESYNC_EN
   localparam int SW = $clog2(MISALIGN_LIMIT + 1);
   logic          offHit;
   logic [SW-1:0] slipCnt;
   logic          slipByte;
`endif

   assign window = {sr[6:0], link.serial_in};

   always_ff @(posedge clk_32f) begin
      if (reset) state <= HUNT;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         HUNT:    if (huntHit) stateNext = LOCK;
         LOCK:    if (syncDone) stateNext = ACTIVE;
                  else if (lockBreak) stateNext = HUNT;
         ACTIVE:  if (resync) stateNext = HUNT;
         default: stateNext = HUNT;
      endcase
   end

   always_comb begin
      byteEnd   = (bitCnt == 3'd7);
      match     = (window == COMMA);
      huntHit   = (state == HUNT) && match;
      lockComma = (state == LOCK) && byteEnd && match;
      lockBreak = (state == LOCK) && byteEnd && !match;
      syncDone  = lockComma && (commaCnt == CW'(SYNC_COUNT - 1));
      resync    = 1'b0;
`ifdef RX_RESYNC_EN
      slipByte  = (state == ACTIVE) && byteEnd && !match && offHit;
      resync    = slipByte && (slipCnt == SW'(MISALIGN_LIMIT - 1));
`endif
      stageEn   = (state == ACTIVE) && byteEnd && !resync;
   end

   // The lane-3 byte is staged at edge E; the whole word moves to the outputs at E+1.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         sr         <= '0;
         bitCnt     <= '0;
         commaCnt   <= '0;
         laneCnt    <= '0;
         stageValid <= '0;
         wordDone   <= 1'b0;
         validR     <= '0;
         strobeR    <= 1'b0;
         activeR    <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            stageData[i] <= '0;
            dataR[i]     <= '0;
         end
      end else begin
         sr       <= window;
         wordDone <= stageEn && (laneCnt == 2'd3);
         strobeR  <= wordDone;
         if (wordDone) begin
            dataR  <= stageData;
            validR <= stageValid;
         end

         if (huntHit)             bitCnt <= '0;
         else if (state != HUNT)  bitCnt <= bitCnt + 3'd1;

         if (huntHit)                     commaCnt <= CW'(1);
         else if (syncDone || lockBreak)  commaCnt <= '0;
         else if (lockComma)              commaCnt <= commaCnt + CW'(1);

         // The first comma found is lane 0, so the lane counter tracks it through LOCK too.
         if (huntHit)                   laneCnt <= 2'd1;
         else if (syncDone)             laneCnt <= '0;
         else if (lockComma || stageEn) laneCnt <= laneCnt + 2'd1;

         if (syncDone)    activeR <= 1'b1;
         else if (resync) activeR <= 1'b0;

         if (stageEn) begin
            stageData[laneCnt]  <= match ? 8'h00 : window;
            stageValid[laneCnt] <= !match;
         end
      end
   end

`ifdef RX_RESYNC_EN
   // offHit collects comma matches at the seven non-boundary offsets of the current byte.
   always_ff @(posedge clk_32f) begin
      if (reset) begin
         offHit  <= 1'b0;
         slipCnt <= '0;
      end else begin
         offHit <= (state == ACTIVE) && !byteEnd && (offHit || match);
         if (state != ACTIVE || resync) slipCnt <= '0;
         else if (byteEnd)              slipCnt <= slipByte ? slipCnt + SW'(1) : '0;
      end
   end
`endif

   assign link.dataOut0   = dataR[0];
   assign link.dataOut1   = dataR[1];
   assign link.dataOut2   = dataR[2];
   assign link.dataOut3   = dataR[3];
   assign link.validOut0  = validR[0];
   assign link.validOut1  = validR[1];
   assign link.validOut2  = validR[2];
   assign link.validOut3  = validR[3];
   assign link.strobe_out = strobeR;
   assign link.active     = activeR;
   assign stateDbg        = state;
endmodule

// File: tb/tb_serial_rx_unstriper.sv
// Bench for serial_rx_unstriper: random and directed bit streams checked every cycle
// against a stream-scanning reference model. Honours RX_RESYNC_EN like the design.
module tb_serial_rx_unstriper;
   localparam logic [7:0] COMMA          = 8'hBC;
   localparam int         SYNC_COUNT     = 4;
   localparam int         MISALIGN_LIMIT = 4;

   logic       clk_32f;
   logic       reset;
   logic [1:0] stateDbg;

   serial_rx_unstriper_if link();

   serial_rx_unstriper #(
      .COMMA(COMMA), .SYNC_COUNT(SYNC_COUNT), .MISALIGN_LIMIT(MISALIGN_LIMIT)
   ) dut (
      .clk_32f (clk_32f),
      .reset   (reset),
      .link    (link),
      .stateDbg(stateDbg)
   );

   initial begin
      clk_32f = 1'b0;
      forever #5 clk_32f = ~clk_32f;
   end

   int          nChecks = 0;
   int          nErrors = 0;
   logic        bits[$];
   logic [35:0] expQ[$];
   logic        mActive;
   logic        mStrobe;
   logic [7:0]  mData [4];
   logic [3:0]  mValid;
   int          riseIdx = -1;
   int          firstStrobe = -1;
   int          lastStrobe = -1;
   logic        prevActive = 1'b0;
   logic        sawFall = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Byte whose last bit was sampled at stream index e; bits before reset release read as 0.
   function automatic logic [7:0] byteAt(input int e);
      logic [7:0] b;
      b = '0;
      for (int k = 7; k >= 0; k--) b = {b[6:0], (e - k >= 0) ? bits[e - k] : 1'b0};
      return b;
   endfunction

`ifdef RX_RESYNC_EN
   function automatic logic offHitAt(input int e);
      for (int j = 1; j <= 7; j++) if (byteAt(e - j) == COMMA) return 1'b1;
      return 1'b0;
   endfunction
`endif

   // Replays the whole stream since reset and leaves in m* what the outputs must show now.
   task automatic modelEval();
      int         last, p, e, h, cnt, lane, slip;
      logic       locked;
      logic [7:0] b;
      logic [7:0] sd [4];
      logic [3:0] sv;
      last = bits.size() - 1;
      mActive = 1'b0;
      mStrobe = 1'b0;
      mValid  = '0;
      sv      = '0;
      for (int i = 0; i < 4; i++) begin
         mData[i] = '0;
         sd[i]    = '0;
      end
      p = 0;
      while (p <= last) begin
         h = -1;
         for (int i = p; i <= last; i++) if (byteAt(i) == COMMA) begin h = i; break; end
         if (h < 0) return;
         cnt = 1; e = h; locked = 1'b0;
         while (!locked) begin
            e += 8;
            if (e > last) return;
            if (byteAt(e) != COMMA) break;
            cnt++;
            if (cnt == SYNC_COUNT) locked = 1'b1;
         end
         if (!locked) begin
            p = e + 1;
            continue;
         end
         mActive = 1'b1;
         lane = 0; slip = 0; p = -1;
         while (p < 0) begin
            e += 8;
            if (e > last) return;
            b = byteAt(e);
`ifdef RX_RESYNC_EN
            if (b != COMMA && offHitAt(e)) slip++;
            else slip = 0;
            if (slip == MISALIGN_LIMIT) begin
               mActive = 1'b0;
               p = e + 1;
               continue;
            end
`endif
            sd[lane]   = (b == COMMA) ? 8'h00 : b;
            sv[lane]   = (b != COMMA);
            if (lane == 3 && e + 1 <= last) begin
               mData   = sd;
               mValid  = sv;
               mStrobe = (e + 1 == last);
            end
            lane = (lane + 1) % 4;
         end
      end
   endtask

   function automatic logic [31:0] dutData();
      return {link.dataOut3, link.dataOut2, link.dataOut1, link.dataOut0};
   endfunction

   function automatic logic [3:0] dutValid();
      return {link.validOut3, link.validOut2, link.validOut1, link.validOut0};
   endfunction

   task automatic compare();
      logic [31:0] expD;
      logic [35:0] w;
      int          idx;
      idx = bits.size() - 1;
      modelEval();
      expD = {mData[3], mData[2], mData[1], mData[0]};
      check("active", link.active, mActive);
      check("strobe", link.strobe_out, mStrobe);
      check("data", dutData(), expD);
      check("valid", dutValid(), mValid);
      if (mStrobe) expQ.push_back({mValid, expD});
      if (link.strobe_out) begin
         check("sb_pending", expQ.size() > 0, 1'b1);
         if (expQ.size() > 0) begin
            w = expQ.pop_front();
            check("sb_word", {dutValid(), dutData()}, w);
         end
         if (firstStrobe < 0) firstStrobe = idx;
         if (lastStrobe >= 0) check("strobe_period", idx - lastStrobe, 32);
         lastStrobe = idx;
      end
      if (link.active && !prevActive) riseIdx = idx;
      if (prevActive && !link.active && idx >= 0) sawFall = 1'b1;
      if (!link.active) lastStrobe = -1;
      prevActive = link.active;
   endtask

   task automatic cycle(input logic b);
      link.serial_in = b;
      @(posedge clk_32f);
      if (reset) begin
         bits.delete();
         expQ.delete();
      end else begin
         bits.push_back(b);
      end
      @(negedge clk_32f);
      compare();
   endtask

   task automatic sendByte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) cycle(b[i]);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      cycle(1'($urandom_range(0, 1)));
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] c;
      c = COMMA;
      reset = 1'b1;
      link.serial_in = 1'b0;

      for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)));
      check("rst_state", stateDbg, 2'd0);
      reset = 1'b0;

      // Idle lock from a random 3-bit prefix.
      riseIdx = -1;
      firstStrobe = -1;
      for (int i = 0; i < 3; i++) cycle(1'($urandom_range(0, 1)));
      for (int i = 0; i < 12; i++) sendByte(COMMA);
      check("lock_rise_idx", riseIdx, 34);
      check("first_strobe_idx", firstStrobe, 67);

      sendByte(8'hFF); sendByte(8'hEE); sendByte(8'hDD); sendByte(8'hCC); sendByte(8'hBB);
      check("word1_data", dutData(), 32'hCCDDEEFF);
      check("word1_valid", dutValid(), 4'hF);
      sendByte(8'hAA); sendByte(8'h99); sendByte(8'h88); sendByte(COMMA);
      check("word2_data", dutData(), 32'h8899AABB);
      check("word2_valid", dutValid(), 4'hF);
      sendByte(COMMA); sendByte(8'h77); sendByte(COMMA); sendByte(COMMA);
      check("partial_data", dutData(), 32'h00770000);
      check("partial_valid", dutValid(), 4'b0100);
      for (int i = 0; i < 3; i++) sendByte(COMMA);

      for (int w = 0; w < 16; w++)
         for (int l = 0; l < 4; l++)
            sendByte(($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom_range(0, 255)));

      // Broken sync: the 55 restarts the comma count.
      pulseReset();
      riseIdx = -1;
      sendByte(COMMA); sendByte(COMMA); sendByte(8'h55);
      for (int i = 0; i < 6; i++) sendByte(COMMA);
      check("broken_rise_idx", riseIdx, 55);
      sendByte(COMMA); sendByte(COMMA);

      // Reset two bytes into a data word.
      sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
      sendByte(8'h55); sendByte(8'h66);
      check("pre_reset_data", dutData(), 32'h44332211);
      pulseReset();
      check("rst_clear_data", dutData(), 32'h0);
      check("rst_clear_valid", dutValid(), 4'h0);
      check("rst_clear_active", link.active, 1'b0);
      for (int i = 0; i < 8; i++) sendByte(COMMA);
      check("relock_active", link.active, 1'b1);

      // Drop one bit of idle while active.
      sawFall = 1'b0;
      for (int i = 7; i >= 1; i--) cycle(c[i]);
      for (int i = 0; i < 12; i++) sendByte(COMMA);
`ifdef RX_RESYNC_EN
      check("slip_fall", sawFall, 1'b1);
`else
      check("slip_fall", sawFall, 1'b0);
`endif
      check("slip_active_end", link.active, 1'b1);
      check("sb_drained", expQ.size(), 0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end
endmodule

// File: doc/serial_rx_unstriper.md
# serial_rx_unstriper

Receive end of the four-lane serial link. It runs on `clk_32f` and samples one bit per cycle from the serial line. It finds byte alignment by hunting for the comma/idle byte, then un-stripes consecutive bytes back onto lanes 0..3, presenting a registered 4-lane word with per-lane valid once every 32 cycles. It sits between the serial line and the lane consumers, mirroring the transmit path that stripes `dataIn0..3`/`validIn0..3` onto the line.

## Interface
- `COMMA`, 8'hBC: idle/alignment byte; the transmitter sends it in place of any invalid lane byte.
- `SYNC_COUNT`, 4: consecutive byte-aligned commas required to reach ACTIVE. Must be a multiple of 4 and ≥4.
- `MISALIGN_LIMIT`, 4: consecutive slipped-comma bytes that force a resync. Used only with `RX_RESYNC_EN`.
- `clk_32f` input 1: the single clock, 32× the lane word rate, one serial bit per cycle.
- `reset` input 1: synchronous, active-high.
- `serial_in` input 1: serial bit, MSB of each byte first.
- `dataOut0..dataOut3` output 8 each: lane bytes.
- `validOut0..validOut3` output 1 each: lane valid.
- `strobe_out` output 1: one-cycle pulse when a new 4-lane word is presented.
- `active` output 1: byte and lane alignment acquired.

## Operation
- Shift register: `window = {sr[6:0], serial_in}`, with `sr <= window` on every cycle.
- HUNT state:
  - `window` is compared to `COMMA` every cycle.
  - On a match: go to LOCK, `comma_cnt=1`, `bit_cnt=0`, `lane_cnt=1`. The next bit is the MSB of the next byte.
- LOCK state:
  - `bit_cnt` counts 0..7.
  - At `bit_cnt==7`, if `window==COMMA`, increment `comma_cnt` and `lane_cnt` (mod 4).
  - If `comma_cnt` reaches `SYNC_COUNT`, go to ACTIVE with `lane_cnt=0`.
  - Any non-comma byte returns to HUNT and clears `comma_cnt`.
- Lane assignment: the transmitter emits idle in whole 4-byte words, so the first comma found is lane 0. Bytes then go to lanes 0,1,2,3 in arrival order.
- ACTIVE state:
  - Each completed byte is written into lane staging register `lane_cnt`.
  - A comma byte stages data 8'h00, valid 0. Any other byte stages data = byte, valid 1.
  - When the lane-3 byte completes, all four staged lanes transfer to the outputs together and `strobe_out` pulses.
  - Outputs hold their values between strobes.
- ACTIVE is left only by `reset`, or by the resync rule when `RX_RESYNC_EN` is defined.
- Reset: `reset` high at an edge puts the block in HUNT and clears all counters, `sr` and staging registers. `dataOut*`=8'h00, `validOut*`=0, `strobe_out`=0, `active`=0. This holds from any state, including mid-byte or mid-word; the partial word is discarded.

## Timing
- All outputs are registered on `clk_32f`.
- `active`:
  - Rises at the edge that samples the last bit of the `SYNC_COUNT`-th comma (the LOCK→ACTIVE transition).
  - Falls at the edge that applies reset or the resync rule.
- Output word latency: the lane-3 byte's last bit is sampled at edge E. `dataOut*`, `validOut*` and `strobe_out=1` appear at E+1. `strobe_out` returns to 0 at E+2.
- Strobe rate: in ACTIVE, strobes occur exactly every 32 cycles.
- First strobe: at least one full word after `active` rises. Commas consumed during LOCK are never output.
- Boundary cases:
  - A comma match in HUNT on the first sampled bit after reset cannot happen, because `sr` resets to 0.
  - Reset and a byte completing on the same edge: reset wins.

## Configuration
- `RX_RESYNC_EN` defined:
  - In ACTIVE, each completed byte that is not `COMMA` on the boundary, but contains a `COMMA` match in `window` at any of the 7 other bit offsets of that byte, increments `slip_cnt`. Any other byte clears it.
  - When `slip_cnt` reaches `MISALIGN_LIMIT`: go to HUNT, `active`=0. Outputs are not cleared; they hold their last values.
- `RX_RESYNC_EN` undefined: no slip detection; ACTIVE persists until `reset`.

## Test plan
- Reset: hold `reset`=1 for 10 cycles with random `serial_in` -> `active`=0, `strobe_out`=0, all `dataOut*`=8'h00 and `validOut*`=0 every cycle.
- Idle lock: 3 random bits, then continuous 8'hBC -> `active` rises at the edge that samples the last bit of the 4th comma. Strobes every 32 cycles thereafter with all `validOut*`=0 and `dataOut*`=8'h00.
- Full word: after lock, send FF EE DD CC -> one strobe with `dataOut0..3`=FF,EE,DD,CC and all valid=1. Next word BB AA 99 88 follows exactly 32 cycles later.
- Partial word: send BC BC 77 BC -> `validOut2`=1, `dataOut2`=8'h77, other valids 0 with data 8'h00.
- Broken sync: send BC BC 55 then idle -> `active` stays 0 through the 55. Lock completes only after 4 fresh consecutive commas.
- Mid-word reset and slip: `reset` for 1 cycle after 2 bytes of a data word -> outputs cleared next cycle and relock is required. With `RX_RESYNC_EN`, drop one bit during idle in ACTIVE -> `active` falls after 4 slipped bytes and relocks on the new alignment.
